// File: rtl/axi_sram_read_arbiter.sv
// Two-master round-robin AXI read arbiter in front of a single SRAM slave (AR/R only).
// Define ARB_TIMEOUT_EN to add the R-channel watchdog that returns a synthetic SLVERR beat.
module axi_sram_read_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  // master 0 (instruction fetch)
  input  logic [3:0]  ARID_M0,
  input  logic [31:0] ARADDR_M0,
  input  logic [3:0]  ARLEN_M0,
  input  logic [2:0]  ARSIZE_M0,
  input  logic [1:0]  ARBURST_M0,
  input  logic        ARVALID_M0,
  output logic        ARREADY_M0,
  output logic [3:0]  RID_M0,
  output logic [31:0] RDATA_M0,
  output logic [1:0]  RRESP_M0,
  output logic        RLAST_M0,
  output logic        RVALID_M0,
  input  logic        RREADY_M0,
  // master 1 (data load)
  input  logic [3:0]  ARID_M1,
  input  logic [31:0] ARADDR_M1,
  input  logic [3:0]  ARLEN_M1,
  input  logic [2:0]  ARSIZE_M1,
  input  logic [1:0]  ARBURST_M1,
  input  logic        ARVALID_M1,
  output logic        ARREADY_M1,
  output logic [3:0]  RID_M1,
  output logic [31:0] RDATA_M1,
  output logic [1:0]  RRESP_M1,
  output logic        RLAST_M1,
  output logic        RVALID_M1,
  input  logic        RREADY_M1,
  // slave
  output logic [7:0]  ARID_S,
  output logic [31:0] ARADDR_S,
  output logic [3:0]  ARLEN_S,
  output logic [2:0]  ARSIZE_S,
  output logic [1:0]  ARBURST_S,
  output logic        ARVALID_S,
  input  logic        ARREADY_S,
  input  logic [7:0]  RID_S,
  input  logic [31:0] RDATA_S,
  input  logic [1:0]  RRESP_S,
  input  logic        RLAST_S,
  input  logic        RVALID_S,
  output logic        RREADY_S
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;   // 0 = M0, 1 = M1
  logic        prio_q, prio_d;

  logic        in_addr_s;
  logic        in_data_s;
  logic [3:0]  arid_g_s;
  logic [31:0] araddr_g_s;
  logic [3:0]  arlen_g_s;
  logic [2:0]  arsize_g_s;
  logic [1:0]  arburst_g_s;
  logic        arvalid_g_s;
  logic        rready_g_s;
  logic        ar_hs_s;
  logic        r_hs_s;
  logic        to_hit_s;
  logic        unused_s;

  logic [3:0]  r_id_s;
  logic [31:0] r_data_s;
  logic [1:0]  r_resp_s;
  logic        r_last_s;
  logic        r_valid_s;

  assign in_addr_s = (state_q == ST_ADDR);
  assign in_data_s = (state_q == ST_DATA);

  // Select the granted master's request and response-ready signals.
  always_comb begin
    if (grant_q) begin
      arid_g_s    = ARID_M1;
      araddr_g_s  = ARADDR_M1;
      arlen_g_s   = ARLEN_M1;
      arsize_g_s  = ARSIZE_M1;
      arburst_g_s = ARBURST_M1;
      arvalid_g_s = ARVALID_M1;
      rready_g_s  = RREADY_M1;
    end else begin
      arid_g_s    = ARID_M0;
      araddr_g_s  = ARADDR_M0;
      arlen_g_s   = ARLEN_M0;
      arsize_g_s  = ARSIZE_M0;
      arburst_g_s = ARBURST_M0;
      arvalid_g_s = ARVALID_M0;
      rready_g_s  = RREADY_M0;
    end
  end

  assign ar_hs_s = in_addr_s & arvalid_g_s & ARREADY_S;
  assign r_hs_s  = in_data_s & RVALID_S & RREADY_S;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] to_cnt_q, to_cnt_d;
  logic [3:0] rid_lat_q, rid_lat_d;

  // The watchdog owns the R channel once the count reaches TIMEOUT.
  assign to_hit_s = in_data_s & (to_cnt_q == 8'(TIMEOUT));
  assign unused_s = ^RID_S[7:4];

  // Watchdog count and master ID captured at AR acceptance.
  always_comb begin
    to_cnt_d  = 8'd0;
    rid_lat_d = rid_lat_q;
    if (ar_hs_s) begin
      rid_lat_d = arid_g_s;
    end else begin
      rid_lat_d = rid_lat_q;
    end
    if (in_data_s && (state_d == ST_DATA)) begin
      if (r_hs_s) begin
        to_cnt_d = 8'd0;
      end else if (to_hit_s) begin
        to_cnt_d = to_cnt_q;
      end else begin
        to_cnt_d = to_cnt_q + 8'd1;
      end
    end else begin
      to_cnt_d = 8'd0;
    end
  end

  // Response source: slave pass-through or synthetic SLVERR last beat.
  always_comb begin
    if (to_hit_s) begin
      r_id_s    = rid_lat_q;
      r_data_s  = 32'h0000_0000;
      r_resp_s  = 2'b10;
      r_last_s  = 1'b1;
      r_valid_s = 1'b1;
    end else begin
      r_id_s    = RID_S[3:0];
      r_data_s  = RDATA_S;
      r_resp_s  = RRESP_S;
      r_last_s  = RLAST_S;
      r_valid_s = RVALID_S;
    end
  end
`else
  assign to_hit_s = 1'b0;
  assign unused_s = ^{RID_S[7:4], (TIMEOUT == 32'd0)};

  // Response source: slave pass-through only.
  always_comb begin
    r_id_s    = RID_S[3:0];
    r_data_s  = RDATA_S;
    r_resp_s  = RRESP_S;
    r_last_s  = RLAST_S;
    r_valid_s = RVALID_S;
  end
`endif

  // Arbitration FSM next state; the grant only changes while idle.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    case (state_q)
      ST_IDLE: begin
        if (ARVALID_M0 && ARVALID_M1) begin
          grant_d = prio_q;
          state_d = ST_ADDR;
        end else if (ARVALID_M0) begin
          grant_d = 1'b0;
          state_d = ST_ADDR;
        end else if (ARVALID_M1) begin
          grant_d = 1'b1;
          state_d = ST_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (ar_hs_s) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        if ((r_hs_s && RLAST_S) || (to_hit_s && rready_g_s)) begin
          state_d = ST_IDLE;
          prio_d  = ~grant_q;
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All arbiter state; reset leaves M0 granted and preferred.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= ST_IDLE;
      grant_q   <= 1'b0;
      prio_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q  <= 8'd0;
      rid_lat_q <= 4'h0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      prio_q    <= prio_d;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
      rid_lat_q <= rid_lat_d;
`endif
    end
  end

  // Slave AR side carries the tagged ID so responses can be traced to a master.
  assign ARVALID_S  = in_addr_s & arvalid_g_s;
  assign ARID_S     = in_addr_s ? {(grant_q ? 4'h2 : 4'h1), arid_g_s} : 8'h00;
  assign ARADDR_S   = in_addr_s ? araddr_g_s  : 32'h0000_0000;
  assign ARLEN_S    = in_addr_s ? arlen_g_s   : 4'h0;
  assign ARSIZE_S   = in_addr_s ? arsize_g_s  : 3'b000;
  assign ARBURST_S  = in_addr_s ? arburst_g_s : 2'b00;
  assign ARREADY_M0 = in_addr_s & ~grant_q & ARREADY_S;
  assign ARREADY_M1 = in_addr_s &  grant_q & ARREADY_S;

  assign RREADY_S   = in_data_s & ~to_hit_s & rready_g_s;

  assign RVALID_M0  = in_data_s & ~grant_q & r_valid_s;
  assign RID_M0     = (in_data_s & ~grant_q) ? r_id_s   : 4'h0;
  assign RDATA_M0   = (in_data_s & ~grant_q) ? r_data_s : 32'h0000_0000;
  assign RRESP_M0   = (in_data_s & ~grant_q) ? r_resp_s : 2'b00;
  assign RLAST_M0   = in_data_s & ~grant_q & r_last_s;

  assign RVALID_M1  = in_data_s & grant_q & r_valid_s;
  assign RID_M1     = (in_data_s & grant_q) ? r_id_s   : 4'h0;
  assign RDATA_M1   = (in_data_s & grant_q) ? r_data_s : 32'h0000_0000;
  assign RRESP_M1   = (in_data_s & grant_q) ? r_resp_s : 2'b00;
  assign RLAST_M1   = in_data_s & grant_q & r_last_s;

endmodule

// File: tb/tb_axi_sram_read_arbiter.sv
// Randomized bench for axi_sram_read_arbiter: transaction-level round-robin model plus slave/master stimulus.
module tb_axi_sram_read_arbiter;
  localparam int unsigned TO = 8;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [3:0]  ARID_M0, ARID_M1, ARLEN_M0, ARLEN_M1;
  logic [31:0] ARADDR_M0, ARADDR_M1;
  logic [2:0]  ARSIZE_M0, ARSIZE_M1;
  logic [1:0]  ARBURST_M0, ARBURST_M1;
  logic        ARVALID_M0, ARVALID_M1, ARREADY_M0, ARREADY_M1;
  logic [3:0]  RID_M0, RID_M1;
  logic [31:0] RDATA_M0, RDATA_M1;
  logic [1:0]  RRESP_M0, RRESP_M1;
  logic        RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1;
  logic [7:0]  ARID_S, RID_S;
  logic [31:0] ARADDR_S, RDATA_S;
  logic [3:0]  ARLEN_S;
  logic [2:0]  ARSIZE_S;
  logic [1:0]  ARBURST_S, RRESP_S;
  logic        ARVALID_S, ARREADY_S, RLAST_S, RVALID_S, RREADY_S;

  axi_sram_read_arbiter #(.TIMEOUT(TO)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0),
    .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
    .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
    .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
    .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1), .ARSIZE_M1(ARSIZE_M1),
    .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
    .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
    .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending request per master and the round-robin pointer.
  bit          pend[2];
  logic [3:0]  m_id[2];
  logic [31:0] m_addr[2];
  logic [3:0]  m_len[2];
  logic [2:0]  m_size[2];
  logic [1:0]  m_burst[2];
  int          prio_m = 0;
  int          grants[$];
  int          burst_no = 0;
  bit          stall_toggle = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rvalid_of(input int m);  return (m == 0) ? RVALID_M0  : RVALID_M1;  endfunction
  function automatic logic arready_of(input int m); return (m == 0) ? ARREADY_M0 : ARREADY_M1; endfunction
  function automatic logic [31:0] rdata_of(input int m); return (m == 0) ? RDATA_M0 : RDATA_M1; endfunction
  function automatic logic [6:0] rmeta_of(input int m);
    return (m == 0) ? {RID_M0, RRESP_M0, RLAST_M0} : {RID_M1, RRESP_M1, RLAST_M1};
  endfunction
  function automatic logic [5:0] quiet_vec();
    return {ARVALID_S, ARREADY_M0, ARREADY_M1, RVALID_M0, RVALID_M1, RREADY_S};
  endfunction

  task automatic step();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic drive_ar();
    ARVALID_M0 = pend[0]; ARID_M0 = m_id[0]; ARADDR_M0 = m_addr[0];
    ARLEN_M0 = m_len[0]; ARSIZE_M0 = m_size[0]; ARBURST_M0 = m_burst[0];
    ARVALID_M1 = pend[1]; ARID_M1 = m_id[1]; ARADDR_M1 = m_addr[1];
    ARLEN_M1 = m_len[1]; ARSIZE_M1 = m_size[1]; ARBURST_M1 = m_burst[1];
  endtask

  task automatic idle_slave();
    ARREADY_S = 1'b0; RVALID_S = 1'b0; RLAST_S = 1'b0; RDATA_S = 32'h0;
    RID_S = 8'h0; RRESP_S = 2'b00; RREADY_M0 = 1'b0; RREADY_M1 = 1'b0;
  endtask

  task automatic new_req(input int m, input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
    pend[m] = 1'b1; m_id[m] = id; m_addr[m] = addr; m_len[m] = len;
    m_size[m] = 3'($urandom_range(0, 2)); m_burst[m] = 2'($urandom_range(0, 2));
  endtask

  task automatic rand_req(input int m);
    new_req(m, 4'($urandom), $urandom, 4'($urandom_range(0, 15)));
  endtask

  // One full burst: IDLE -> ADDR -> DATA -> IDLE, or aborted by reset after abort_at beats.
  task automatic run_round(input int abort_at);
    int g, ng, beats, guard, idle_run;
    bit hs, done;
    logic rready_g;
    g  = (pend[0] && pend[1]) ? prio_m : (pend[0] ? 0 : 1);
    ng = 1 - g;
    idle_slave();
    drive_ar();
    #1;
    check_eq("idle_quiet", 32'(quiet_vec()), 32'h0);
    step();
    hs = 1'b0; guard = 0;
    while (!hs && guard < 20) begin
      ARREADY_S = (guard >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      check_eq("arvalid_s", 32'(ARVALID_S), 32'h1);
      check_eq("arid_s", 32'(ARID_S), 32'({(g == 0) ? 4'h1 : 4'h2, m_id[g]}));
      check_eq("araddr_s", ARADDR_S, m_addr[g]);
      check_eq("ar_fields", 32'({ARLEN_S, ARSIZE_S, ARBURST_S}), 32'({m_len[g], m_size[g], m_burst[g]}));
      check_eq("arready_g", 32'(arready_of(g)), 32'(ARREADY_S));
      check_eq("arready_ng", 32'(arready_of(ng)), 32'h0);
      hs = ARREADY_S;
      guard++;
      step();
    end
    pend[g] = 1'b0;
    grants.push_back(g);
    burst_no++;
    beats = 0; idle_run = 0; guard = 0; done = 1'b0;
    while (!done && guard < 200) begin
      drive_ar();
      ARREADY_S = 1'($urandom_range(0, 1));
      RVALID_S  = (stall_toggle || idle_run >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      rready_g  = stall_toggle ? ((guard % 2) == 0) : ((idle_run >= 3) ? 1'b1 : 1'($urandom_range(0, 1)));
      RDATA_S   = {8'(burst_no), 8'(beats), 16'($urandom)};
      RID_S     = {4'($urandom), m_id[g]};
      RRESP_S   = 2'($urandom);
      RLAST_S   = (beats == int'(m_len[g]));
      if (g == 0) begin RREADY_M0 = rready_g; RREADY_M1 = 1'($urandom_range(0, 1)); end
      else        begin RREADY_M1 = rready_g; RREADY_M0 = 1'($urandom_range(0, 1)); end
      if (abort_at >= 0 && beats == abort_at) begin
        RVALID_S = 1'b1; ARREADY_S = 1'b1; RREADY_M0 = 1'b1; RREADY_M1 = 1'b1;
        #1;
        check_eq("pre_reset_rvalid", 32'(rvalid_of(g)), 32'h1);
        ARESETn = 1'b0;
        #1;
        check_eq("async_reset_quiet", 32'(quiet_vec()), 32'h0);
        check_eq("async_reset_rdata", rdata_of(g), 32'h0);
        step();
        check_eq("in_reset_quiet", 32'(quiet_vec()), 32'h0);
        #1;
        ARESETn = 1'b1;
        pend[0] = 1'b0; pend[1] = 1'b0; prio_m = 0;
        idle_slave();
        drive_ar();
        step();
        return;
      end
      #1;
      check_eq("rvalid_g", 32'(rvalid_of(g)), 32'(RVALID_S));
      check_eq("rvalid_ng", 32'(rvalid_of(ng)), 32'h0);
      check_eq("rready_s", 32'(RREADY_S), 32'(rready_g));
      check_eq("data_no_ar", 32'({ARVALID_S, ARREADY_M0, ARREADY_M1}), 32'h0);
      check_eq("rdata_ng", rdata_of(ng), 32'h0);
      if (RVALID_S) begin
        check_eq("rdata_g", rdata_of(g), RDATA_S);
        check_eq("beat_order", 32'(rdata_of(g)[23:16]), 32'(8'(beats)));
        check_eq("rmeta_g", 32'(rmeta_of(g)), 32'({m_id[g], RRESP_S, beats == int'(m_len[g])}));
      end
      if (RVALID_S && rready_g) begin
        beats++; idle_run = 0;
        if (RLAST_S) done = 1'b1;
      end else begin
        idle_run++;
      end
      guard++;
      step();
    end
    check_eq("burst_done", 32'(done), 32'h1);
    check_eq("beat_count", beats, int'(m_len[g]) + 1);
    prio_m = 1 - g;
    idle_slave();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_id[m] = 4'h0; m_addr[m] = 32'h0; m_len[m] = 4'h0; m_size[m] = 3'b000; m_burst[m] = 2'b00;
    end
    ARESETn = 1'b0;
    idle_slave();
    drive_ar();
    ARVALID_M0 = 1'b1;
    ARVALID_M1 = 1'b1;
    RVALID_S   = 1'b1;
    repeat (3) @(negedge ACLK);
    #1;
    check_eq("reset_quiet", 32'(quiet_vec()), 32'h0);
    check_eq("reset_ids", 32'({ARID_S, RID_M0, RID_M1}), 32'h0);
    check_eq("reset_rdata", RDATA_M0 | RDATA_M1, 32'h0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    idle_slave();
    drive_ar();
    step();

    // Both request together after reset; served master re-requests: M0, M1, M0, M1.
    rand_req(0); rand_req(1);
    for (int i = 0; i < 4; i++) begin
      run_round(-1);
      rand_req(1 - prio_m);
    end
    for (int i = 0; i < 4; i++) check_eq("alternate_grant", grants[i], i % 2);
    pend[0] = 1'b0; pend[1] = 1'b0;

    // M1 alone, LEN=3, RREADY toggling.
    stall_toggle = 1'b1;
    new_req(1, 4'h9, 32'h0000_2000, 4'd3);
    run_round(-1);
    stall_toggle = 1'b0;

    // M0 alone: ADDR 0x10, LEN 0, ID 3 -> ARID_S 8'h13; leaves prio at M1.
    new_req(0, 4'h3, 32'h0000_0010, 4'd0);
    run_round(-1);

    // Reset during beat 2 of a LEN=7 burst, then both request: M0 must win.
    new_req(0, 4'h6, 32'h0000_0100, 4'd7);
    run_round(1);
    rand_req(0); rand_req(1);
    run_round(-1);
    check_eq("post_reset_grant", grants[grants.size() - 1], 0);
    run_round(-1);

    for (int r = 0; r < 30; r++) begin
      for (int m = 0; m < 2; m++) if (!pend[m] && ($urandom_range(0, 1) == 1)) rand_req(m);
      if (!pend[0] && !pend[1]) rand_req($urandom_range(0, 1));
      run_round(-1);
    end

`ifdef ARB_TIMEOUT_EN
    // Silent slave: synthetic SLVERR beat after TO cycles in DATA, then pending M1 is served.
    pend[0] = 1'b0; pend[1] = 1'b0;
    while (prio_m != 0) begin
      new_req(1, 4'h1, 32'h0, 4'd0);
      run_round(-1);
    end
    new_req(0, 4'h5, 32'h0000_0400, 4'd3);
    idle_slave();
    drive_ar();
    step();
    ARREADY_S = 1'b1;
    #1;
    check_eq("to_arvalid", 32'(ARVALID_S), 32'h1);
    step();
    pend[0] = 1'b0;
    new_req(1, 4'hA, 32'h0000_0800, 4'd1);
    idle_slave();
    drive_ar();
    for (int k = 0; k <= int'(TO); k++) begin
      #1;
      check_eq("to_wait_rvalid", 32'(RVALID_M0), (k == int'(TO)) ? 32'h1 : 32'h0);
      check_eq("to_no_ar", 32'({ARVALID_S, ARREADY_M1}), 32'h0);
      step();
    end
    #1;
    check_eq("to_hold_rvalid", 32'(RVALID_M0), 32'h1);
    RREADY_M0 = 1'b1;
    #1;
    check_eq("to_meta", 32'({RID_M0, RRESP_M0, RLAST_M0}), 32'({4'h5, 2'b10, 1'b1}));
    check_eq("to_rdata", RDATA_M0, 32'h0);
    check_eq("to_rready_s", 32'(RREADY_S), 32'h0);
    step();
    prio_m = 1;
    run_round(-1);
    check_eq("to_next_grant", grants[grants.size() - 1], 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_sram_read_arbiter.md
Name: axi_sram_read_arbiter

Overview:
- Two-master to one-slave AXI read-channel arbiter placed in front of the SRAM slave's AR/R ports.
- The two masters are M0 (instruction fetch) and M1 (data load).
- It grants one read burst at a time using round-robin priority, routes the AR and R channels, tags slave IDs with the master number, and holds the grant until the R handshake that carries RLAST.

Parameters:
- TIMEOUT, 255, maximum number of cycles the DATA state waits for the next R handshake; used only with ARB_TIMEOUT_EN; range 1..255.

Ports:
- ACLK  in  1  clock; all state updates on rising edge.
- ARESETn  in  1  reset, asynchronous, active-low.
- ARID_M0, ARID_M1  in  4  master read IDs.
- ARADDR_M0, ARADDR_M1  in  32  read addresses.
- ARLEN_M0, ARLEN_M1  in  4  burst length minus 1.
- ARSIZE_M0, ARSIZE_M1  in  3  transfer size.
- ARBURST_M0, ARBURST_M1  in  2  burst type.
- ARVALID_M0, ARVALID_M1  in  1  address valid.
- ARREADY_M0, ARREADY_M1  out  1  address ready.
- RID_M0, RID_M1  out  4  returned ID, lower 4 bits of RID_S.
- RDATA_M0, RDATA_M1  out  32  read data.
- RRESP_M0, RRESP_M1  out  2  read response.
- RLAST_M0, RLAST_M1  out  1  last beat.
- RVALID_M0, RVALID_M1  out  1  data valid.
- RREADY_M0, RREADY_M1  in  1  data ready.
- ARID_S  out  8  slave ID = {tag, ARID_Mx}; tag 4'h1 for M0, 4'h2 for M1.
- ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S  out  32/4/3/2  muxed AR fields.
- ARVALID_S  out  1; ARREADY_S  in  1.
- RID_S  in  8; RDATA_S  in  32; RRESP_S  in  2; RLAST_S  in  1; RVALID_S  in  1.
- RREADY_S  out  1.

Behaviour:
- Reset: state=IDLE, prio=M0, grant=M0, timeout counter=0.
- Reset outputs: ARVALID_S, ARREADY_Mx, RVALID_Mx, RREADY_S all 0. Data and ID outputs are 0 while not granted.
- States are IDLE, ADDR, DATA.
- IDLE: all ready/valid outputs are 0.
  - One ARVALID_Mx high → grant that master.
  - Both high → grant the master equal to prio.
  - Grant is registered; next state is ADDR.
  - Neither high → stay in IDLE.
- ADDR: the granted master's AR fields drive the slave. ARVALID_S = ARVALID_Mg and ARREADY_Mg = ARREADY_S. The non-granted ARREADY is 0.
  - On ARVALID_S & ARREADY_S → DATA.
  - Minimum latency from request to ARVALID_S is 1 cycle.
- DATA:
  - RVALID_Mg = RVALID_S and RREADY_S = RREADY_Mg.
  - RID/RDATA/RRESP/RLAST pass through to the granted master.
  - The non-granted master's RVALID is 0; no AR is accepted from either master.
  - On RVALID_S & RREADY_S & RLAST_S → IDLE and prio = ~grant (round robin).
  - An RLAST beat stalled by RREADY=0 holds the state.
- Beat counting: LEN=0..15 gives 1..16 beats. The arbiter does not count beats; termination is decided by RLAST_S alone.
- Upper RID_S bits not matching the tag of the granted master are ignored; the lower 4 bits are still forwarded.
- A request that drops ARVALID in ADDR is an AXI violation. The state holds; no recovery is required.
- Async reset in any state returns immediately to the reset values. An in-flight burst is abandoned, and the slave side is reset by the same ARESETn.
- Only one outstanding burst at a time; no pipelining of AR while in DATA.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - In DATA, an 8-bit counter increments on each cycle without an R handshake and clears on each handshake.
  - When the count reaches TIMEOUT, the arbiter drives a synthetic beat to the granted master: RVALID=1, RRESP=2'b10 (SLVERR), RLAST=1, RDATA=0, RID=latched ARID.
  - The state moves to IDLE on that beat's RREADY_Mg; prio flips and the counter clears.
  - During the synthetic beat, RREADY_S=0.
- ARB_TIMEOUT_EN undefined: no counter; DATA waits indefinitely.

Test Plan:
- M0 only, ARADDR=0x0000_0010, LEN=0, ARID=4'h3 → ARID_S=8'h13 one cycle after the request. One beat is routed to M0 with RID_M0=4'h3 and RLAST=1; RVALID_M1 stays 0.
- M0 and M1 request in the same cycle after reset → M0 is served first. M1's ARREADY_M1=0 until M0's RLAST handshake, then M1's AR issues with ARID_S=8'h2x.
- Both masters request continuously for 4 bursts → grants alternate M0, M1, M0, M1.
- M1 burst with LEN=3 and RREADY_M1 toggling 1,0,1,0… → 4 beats delivered in order. The state stays DATA during stalls and returns to IDLE only after the 4th beat handshakes.
- ARESETn pulsed low during beat 2 of a LEN=7 burst → all valid/ready outputs go 0 immediately; after release, state is IDLE and prio is M0.
- ARB_TIMEOUT_EN, TIMEOUT=8, slave never asserts RVALID_S → after 8 cycles in DATA, M0 receives RRESP=2'b10 and RLAST=1. The arbiter then serves a pending M1 request.
